// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the radix-4 Booth multiply sequencer.
//   state_e     : sequencer states (IDLE / RUN / DONE), 2-bit encoding
//   digit_e     : decoded Booth digit (0, +M, +2M, -M, -2M)
//   boothDecode : maps a 3-bit multiplier window {Q[2j+1], Q[2j], Q[2j-1]}
//                 onto its Booth digit
// ---------------------------------------------------------------------------
package mul_pkg;

    // Sequencer states. The encoding is fixed so that other blocks and
    // debug tooling can rely on the raw values.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Booth digit codes.
    typedef enum logic [2:0] {
        DIG_0  = 3'd0,
        DIG_P1 = 3'd1,
        DIG_P2 = 3'd2,
        DIG_M1 = 3'd3,
        DIG_M2 = 3'd4
    } digit_e;

    // Radix-4 recoding of one overlapping 3-bit multiplier window.
    function automatic digit_e boothDecode(input logic [2:0] group);
        digit_e digit;
        case (group)
            3'b000, 3'b111: digit = DIG_0;
            3'b001, 3'b010: digit = DIG_P1;
            3'b011:         digit = DIG_P2;
            3'b100:         digit = DIG_M2;
            default:        digit = DIG_M1;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// ---------------------------------------------------------------------------
// booth_digit_sel
// Combinational Booth partial-product selector.
//   i_group : 3-bit multiplier window {Q[2j+1], Q[2j], Q[2j-1]}
//   i_m     : signed multiplicand M
//   o_pp    : signed WIDTH+2 bit partial product (0, +M, +2M, -M, -2M)
// ---------------------------------------------------------------------------
module booth_digit_sel
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]              i_group,
    input  logic [WIDTH-1:0]        i_m,
    output logic signed [WIDTH+1:0] o_pp
);

    logic signed [WIDTH+1:0] w_mExt;
    digit_e                  w_digit;

    // M is sign-extended by two bits before doubling or negating so that
    // +/-2M of the most negative M still fits without overflow.
    assign w_mExt  = {{2{i_m[WIDTH-1]}}, i_m};
    assign w_digit = boothDecode(i_group);

    // Select the partial product for this digit.
    always_comb begin
        o_pp = '0;
        case (w_digit)
            DIG_0:   o_pp = '0;
            DIG_P1:  o_pp = w_mExt;
            DIG_P2:  o_pp = w_mExt <<< 1;
            DIG_M1:  o_pp = -w_mExt;
            DIG_M2:  o_pp = -(w_mExt <<< 1);
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// booth_mul_seq_ctrl
// Sequencer for a radix-4 Booth signed multiplier. Retires one Booth digit
// (two multiplier bits) per clock and returns the 2*WIDTH bit product with
// one-cycle HI/LO write enables. WIDTH must be even.
//   clock        : rising-edge clock
//   clear        : asynchronous active-high reset
//   start        : multiply request, only looked at in IDLE
//   flush        : synchronous abort while RUN
//   multiplicand : signed M, captured on the accepting edge
//   multiplier   : signed Q, captured on the accepting edge
//   busy         : high in RUN and DONE
//   done         : one-cycle result-valid pulse
//   hi_we, lo_we : copies of done, write enables for HI and LO
//   hi_out       : upper half of the last completed product
//   lo_out       : lower half of the last completed product
// ---------------------------------------------------------------------------
module booth_mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int ITER   = WIDTH / 2;
    localparam int CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PROD_W = 2 * WIDTH;

    state_e                  r_state;
    state_e                  w_nextState;
    logic [CNT_W-1:0]        r_cnt;
    logic [WIDTH-1:0]        r_m;
    logic [WIDTH-1:0]        r_q;
    logic                    r_qPrev;
    logic [PROD_W-1:0]       r_acc;
    logic [PROD_W-1:0]       r_result;

    logic [2:0]              w_group;
    logic signed [WIDTH+1:0] w_pp;
    logic [PROD_W-1:0]       w_ppExt;
    logic [CNT_W:0]          w_shiftAmt;
    logic [PROD_W-1:0]       w_ppShift;
    logic [PROD_W-1:0]       w_accNext;
    logic                    w_lastDigit;

    // The low two bits of the shifting Q plus the bit shifted out last time
    // form the current Booth window; r_qPrev starts at 0 for Q[-1].
    assign w_group = {r_q[1], r_q[0], r_qPrev};

    booth_digit_sel #(
        .WIDTH (WIDTH)
    ) u_digitSel (
        .i_group (w_group),
        .i_m     (r_m),
        .o_pp    (w_pp)
    );

    // Sign-extend the partial product to full product width and weight it
    // by 4^j; the sum wraps modulo 2^(2*WIDTH), which is exactly the signed
    // product once all digits are in.
    assign w_ppExt     = PROD_W'(w_pp);
    assign w_shiftAmt  = {r_cnt, 1'b0};
    assign w_ppShift   = w_ppExt << w_shiftAmt;
    assign w_accNext   = r_acc + w_ppShift;
    assign w_lastDigit = (r_cnt == CNT_W'(ITER - 1));

    // State register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. flush beats the final digit, so an aborted op never
    // reaches DONE; DONE always lasts exactly one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_nextState = S_IDLE;
                end else if (w_lastDigit) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded purely from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign hi_we  = done;
    assign lo_we  = done;
    assign hi_out = r_result[PROD_W-1:WIDTH];
    assign lo_out = r_result[WIDTH-1:0];

    // Datapath: operands are captured on the accepting edge, then every RUN
    // edge folds one digit into the accumulator and shifts Q right by two.
    // A flushed RUN cycle leaves everything untouched, including the result.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_cnt    <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_qPrev  <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_qPrev <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_acc   <= w_accNext;
                        r_q     <= r_q >> 2;
                        r_qPrev <= r_q[1];
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (w_lastDigit) begin
                            r_result <= w_accNext;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_seq_ctrl
// Self-checking bench for booth_mul_seq_ctrl (WIDTH = 32): directed vector
// table, hand-written multi-cycle corner cases, and random back-to-back ops
// against a $signed reference product.
// ---------------------------------------------------------------------------
module tb_booth_mul_seq_ctrl;

    logic        clock;
    logic        clear;
    logic        start;
    logic        flush;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic        hiWe;
    logic        loWe;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] expected;
    } vec_t;

    vec_t vecs[11];

    booth_mul_seq_ctrl #(
        .WIDTH (32)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .flush        (flush),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi_we        (hiWe),
        .lo_we        (loWe),
        .hi_out       (hiOut),
        .lo_out       (loOut)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one value against its expectation and report a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    // Request one multiply starting at a negedge and run it to the done pulse.
    // Acceptance is recognised as the first sample with busy=1 and done=0, so
    // this also works when called while the previous op is still in DONE.
    // latency counts clock edges from the accepting edge to the done sample.
    task automatic applyStimulus(input logic [31:0] m, input logic [31:0] q,
                                 output logic [63:0] prod, output int latency,
                                 output bit weOk, output bit busyHeld,
                                 output bit timedOut);
        bit accepted;
        bit finished;
        prod     = '0;
        latency  = 0;
        weOk     = 1'b0;
        busyHeld = 1'b1;
        timedOut = 1'b0;
        accepted = 1'b0;
        finished = 1'b0;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        for (int i = 0; i < 8 && !accepted; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (busy && !done) accepted = 1'b1;
        end
        start = 1'b0;
        if (!accepted) begin
            timedOut = 1'b1;
            return;
        end
        for (int i = 0; i < 40 && !finished; i++) begin
            @(posedge clock);
            @(negedge clock);
            latency++;
            if (done) begin
                finished = 1'b1;
                prod     = {hiOut, loOut};
                weOk     = hiWe && loWe;
            end else if (!busy) begin
                busyHeld = 1'b0;
            end
        end
        if (!finished) timedOut = 1'b1;
    endtask

    initial begin
        logic [63:0] prod;
        logic [63:0] firstProd;
        logic [63:0] secondProd;
        logic [31:0] rm;
        logic [31:0] rq;
        longint      refProd;
        int          latency;
        int          doneCount;
        bit          weOk;
        bit          busyHeld;
        bit          timedOut;
        bit          seen;

        vecs[0]  = '{"m7_qm3",      32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1]  = '{"min_min",     32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[2]  = '{"max_max",     32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[3]  = '{"min_one",     32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000};
        vecs[4]  = '{"max_min",     32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[5]  = '{"m1_max",      32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001};
        vecs[6]  = '{"zero_x",      32'd0,         32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[7]  = '{"p16_p16",     32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[8]  = '{"m2_p3",       32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA};
        vecs[9]  = '{"m1_m1",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[10] = '{"p3_p5",       32'd3,         32'd5,         64'h0000_0000_0000_000F};

        checks       = 0;
        errors       = 0;
        clear        = 1'b1;
        start        = 1'b0;
        flush        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        // Reset state.
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_we",   64'({hiWe, loWe}), 64'd0);
        checkOutput("reset_prod", {hiOut, loOut}, 64'd0);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        // Directed vector table: product, latency, write enables, one-cycle done.
        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].m, vecs[v].q, prod, latency, weOk, busyHeld, timedOut);
            checkOutput({vecs[v].name, "_timeout"}, 64'(timedOut), 64'd0);
            checkOutput({vecs[v].name, "_prod"}, prod, vecs[v].expected);
            checkOutput({vecs[v].name, "_latency"}, 64'(latency), 64'd16);
            checkOutput({vecs[v].name, "_we"}, 64'(weOk), 64'd1);
            checkOutput({vecs[v].name, "_busy_held"}, 64'(busyHeld), 64'd1);
            @(posedge clock);
            @(negedge clock);
            checkOutput({vecs[v].name, "_done_drop"}, 64'(done), 64'd0);
            checkOutput({vecs[v].name, "_idle_busy"}, 64'(busy), 64'd0);
        end

        // start held high through RUN with operands changed at cycle 5.
        multiplicand = 32'd11;
        multiplier   = 32'd13;
        start        = 1'b1;
        seen         = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (busy && !done) seen = 1'b1;
        end
        checkOutput("hold_accept", 64'(seen), 64'd1);
        doneCount = 0;
        firstProd = '0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (c == 5) begin
                multiplicand = 32'hFFFF_FFFB;
                multiplier   = 32'd9;
            end
            if (done) begin
                doneCount++;
                firstProd = {hiOut, loOut};
            end
        end
        checkOutput("hold_done_count", 64'(doneCount), 64'd1);
        checkOutput("hold_first_prod", firstProd, 64'h0000_0000_0000_008F);
        seen       = 1'b0;
        secondProd = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                seen       = 1'b1;
                secondProd = {hiOut, loOut};
            end
        end
        start = 1'b0;
        checkOutput("hold_second_seen", 64'(seen), 64'd1);
        checkOutput("hold_second_prod", secondProd, 64'hFFFF_FFFF_FFFF_FFD3);
        repeat (2) @(negedge clock);

        // Asynchronous clear in the middle of RUN.
        multiplicand = 32'h0000_1234;
        multiplier   = 32'h0000_5678;
        start        = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        clear = 1'b1;
        #1;
        checkOutput("clear_busy", 64'(busy), 64'd0);
        checkOutput("clear_done", 64'(done), 64'd0);
        checkOutput("clear_prod", {hiOut, loOut}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        applyStimulus(32'd3, 32'd5, prod, latency, weOk, busyHeld, timedOut);
        checkOutput("after_clear_prod", prod, 64'd15);
        checkOutput("after_clear_latency", 64'(latency), 64'd16);
        @(posedge clock);
        @(negedge clock);

        // flush at RUN cycle 10: back to IDLE, no done, result keeps 15.
        multiplicand = 32'h0000_1234;
        multiplier   = 32'h0000_5678;
        start        = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_prod", {hiOut, loOut}, 64'd15);
        doneCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done) doneCount++;
        end
        checkOutput("flush_no_done", 64'(doneCount), 64'd0);
        checkOutput("flush_prod_kept", {hiOut, loOut}, 64'd15);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, prod, latency, weOk, busyHeld, timedOut);
        checkOutput("after_flush_prod", prod, 64'd1);

        // Random back-to-back ops against the signed reference product.
        for (int n = 0; n < 2000; n++) begin
            rm = $urandom;
            rq = $urandom;
            refProd = longint'($signed(rm)) * longint'($signed(rq));
            applyStimulus(rm, rq, prod, latency, weOk, busyHeld, timedOut);
            checkOutput("rand_prod", prod, 64'(refProd));
            checkOutput("rand_busy_held", 64'(busyHeld), 64'd1);
            if (timedOut) begin
                checkOutput("rand_timeout", 64'(timedOut), 64'd0);
                break;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
